alu_decoder: RTL and testbench
==============================

ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 The parameter CTRL_RST, default 4'b0000, SHALL set the aluControl value loaded on reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  qualifies aluop/opcode/funct for capture this cycle.
REQ-005 aluop  input  2  main-controller ALU class: 00 mem, 01 branch, 10 I-type, 11 R-type.
REQ-006 opcode  input  6  instruction opcode, used only when aluop=10.
REQ-007 funct  input  6  instruction funct field, used only when aluop=11.
REQ-008 aluControl  output  4  registered ALU operation code.
REQ-009 out_valid  output  1  high for one cycle per captured in_valid, aligned with the aluControl update.

Function
REQ-010 Encodings SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, ILLEGAL=1111.
REQ-011 aluop=00 SHALL decode to ADD and aluop=01 to SUB, whatever the opcode and funct values (including X/Z in simulation).
REQ-012 aluop=10 SHALL decode opcode as: 001000 ADD, 001100 AND, 001101 OR, 001010 SLT, any other opcode ILLEGAL; funct is ignored.
REQ-013 aluop=11 SHALL decode funct as: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, any other funct ILLEGAL; opcode is ignored.
REQ-014 Decode logic SHALL be combinational, and its result SHALL be registered into aluControl on the rising edge where in_valid=1, giving a latency of exactly 1 cycle.
REQ-015 When in_valid=0, aluControl SHALL hold its previous value and out_valid SHALL be 0 on the next cycle.
REQ-016 Back-to-back in_valid SHALL give one new result per cycle with no bubbles.
REQ-017 No decode path SHALL infer a latch, and every case SHALL have an explicit default of ILLEGAL.

Reset
REQ-018 When rst_n=0 at a rising clk edge, aluControl SHALL load CTRL_RST and out_valid SHALL load 0, and reset SHALL take priority over a simultaneous in_valid.
REQ-019 A reset asserted mid-stream SHALL discard the in-flight result, and the first output after rst_n rises SHALL come from an in_valid sampled on or after that edge.

Configuration
REQ-020 With ALU_DECODER_ILLEGAL_FLAG_EN defined, the block SHALL add an output port illegal (1 bit), registered with aluControl, that is high exactly when the captured code is ILLEGAL and resets to 0.
REQ-021 Without ALU_DECODER_ILLEGAL_FLAG_EN, the illegal port and its register SHALL be absent, and aluControl behaviour SHALL be identical in both builds.

Verification
REQ-022 The bench SHALL drive aluop=00 then 01 with opcode/funct=X and in_valid=1 -> aluControl 0010 then 0110, each one cycle later, with no X on the output.
REQ-023 The bench SHALL drive aluop=10 with opcode 001000, 001100, 001101, 001010, 111111 -> aluControl 0010, 0000, 0001, 0111, 1111.
REQ-024 The bench SHALL drive aluop=11, opcode=000000 with funct 100000, 100010, 100100, 100101, 101010, 111111 -> aluControl 0010, 0110, 0000, 0001, 0111, 1111.
REQ-025 The bench SHALL capture SUB, then hold in_valid=0 for 3 cycles -> aluControl stays 0110 and out_valid=0.
REQ-026 The bench SHALL assert rst_n=0 in the same cycle as in_valid=1 with add funct -> aluControl=CTRL_RST and out_valid=0 on the next edge.
REQ-027 With ALU_DECODER_ILLEGAL_FLAG_EN defined, the bench SHALL drive aluop=11, funct=111111 -> illegal=1, then funct=100000 -> illegal=0.

Source files
------------

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// alu_decoder : registered ALU-control decoder (aluop/opcode/funct -> aluControl)
// Optional    : ALU_DECODER_ILLEGAL_FLAG_EN adds a registered 'illegal' flag.
// Revision    : 1.0
// ============================================================================
module alu_decoder #(
  parameter logic [3:0] CTRL_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] aluop,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluControl,
  output logic       out_valid
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [3:0] c_ALU_AND     = 4'b0000;
  localparam logic [3:0] c_ALU_OR      = 4'b0001;
  localparam logic [3:0] c_ALU_ADD     = 4'b0010;
  localparam logic [3:0] c_ALU_SUB     = 4'b0110;
  localparam logic [3:0] c_ALU_SLT     = 4'b0111;
  localparam logic [3:0] c_ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] c_OP_MEM    = 2'b00;
  localparam logic [1:0] c_OP_BRANCH = 2'b01;
  localparam logic [1:0] c_OP_ITYPE  = 2'b10;
  localparam logic [1:0] c_OP_RTYPE  = 2'b11;

  localparam logic [5:0] c_OPC_ADDI = 6'b001000;
  localparam logic [5:0] c_OPC_ANDI = 6'b001100;
  localparam logic [5:0] c_OPC_ORI  = 6'b001101;
  localparam logic [5:0] c_OPC_SLTI = 6'b001010;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  logic [3:0] itype_code;
  logic [3:0] rtype_code;
  logic [3:0] dec_code;
  logic [3:0] ctrl_d, ctrl_q;
  logic       valid_d, valid_q;

  always_comb begin
    itype_code = c_ALU_ILLEGAL;
    case (opcode)
      c_OPC_ADDI: itype_code = c_ALU_ADD;
      c_OPC_ANDI: itype_code = c_ALU_AND;
      c_OPC_ORI:  itype_code = c_ALU_OR;
      c_OPC_SLTI: itype_code = c_ALU_SLT;
      default:    itype_code = c_ALU_ILLEGAL;
    endcase
  end

  always_comb begin
    rtype_code = c_ALU_ILLEGAL;
    case (funct)
      c_FN_ADD: rtype_code = c_ALU_ADD;
      c_FN_SUB: rtype_code = c_ALU_SUB;
      c_FN_AND: rtype_code = c_ALU_AND;
      c_FN_OR:  rtype_code = c_ALU_OR;
      c_FN_SLT: rtype_code = c_ALU_SLT;
      default:  rtype_code = c_ALU_ILLEGAL;
    endcase
  end

  // mem/branch select constants directly so unknown opcode/funct never leak through
  always_comb begin
    dec_code = c_ALU_ILLEGAL;
    case (aluop)
      c_OP_MEM:    dec_code = c_ALU_ADD;
      c_OP_BRANCH: dec_code = c_ALU_SUB;
      c_OP_ITYPE:  dec_code = itype_code;
      c_OP_RTYPE:  dec_code = rtype_code;
      default:     dec_code = c_ALU_ILLEGAL;
    endcase
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;
    if (in_valid) begin
      ctrl_d  = dec_code;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_RST;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign aluControl = ctrl_q;
  assign out_valid  = valid_q;

`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = illegal_q;
    if (in_valid) begin
      illegal_d = (dec_code == c_ALU_ILLEGAL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_decoder.sv
`default_nettype none
// ============================================================================
// tb_alu_decoder : randomized + directed self-checking bench for alu_decoder
// Revision       : 1.0
// ============================================================================
module tb_alu_decoder;

  localparam logic [3:0] CTRL_RST = 4'b1010;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] aluop;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] aluControl;
  logic       out_valid;
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  int tests;
  int fails;

  // expected state, advanced by the reference model every clock
  logic [3:0] exp_ctrl;
  logic       exp_valid;
  logic       exp_ill;

  logic [3:0] itab [logic [5:0]];
  logic [3:0] rtab [logic [5:0]];

  alu_decoder #(.CTRL_RST(CTRL_RST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .aluop      (aluop),
    .opcode     (opcode),
    .funct      (funct),
    .aluControl (aluControl),
    .out_valid  (out_valid)
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
    ,
    .illegal    (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] opc,
                                            input logic [5:0] fn);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd2) return itab.exists(opc) ? itab[opc] : 4'b1111;
    return rtab.exists(fn) ? rtab[fn] : 4'b1111;
  endfunction

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic rn, input logic v, input logic [1:0] op,
                       input logic [5:0] opc, input logic [5:0] fn);
    @(negedge clk);
    rst_n = rn; in_valid = v; aluop = op; opcode = opc; funct = fn;
    @(posedge clk);
    if (!rn) begin
      exp_ctrl = CTRL_RST; exp_valid = 1'b0; exp_ill = 1'b0;
    end else if (v) begin
      exp_ctrl = ref_decode(op, opc, fn); exp_valid = 1'b1; exp_ill = (exp_ctrl == 4'b1111);
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    cycle(1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    tests++;
    if (aluControl !== CTRL_RST || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset: ctrl=%b valid=%b, want ctrl=%b valid=0", aluControl, out_valid, CTRL_RST);
    end
  endtask

  task automatic test_mem_branch();
    cycle(1'b1, 1'b1, 2'b00, 6'bx, 6'bx);
    tests++;
    if (aluControl !== 4'b0010 || out_valid !== 1'b1 || $isunknown(aluControl)) begin
      fails++;
      $display("FAIL mem_add: ctrl=%b valid=%b, want 0010/1", aluControl, out_valid);
    end
    cycle(1'b1, 1'b1, 2'b01, 6'bx, 6'bx);
    tests++;
    if (aluControl !== 4'b0110 || out_valid !== 1'b1 || $isunknown(aluControl)) begin
      fails++;
      $display("FAIL branch_sub: ctrl=%b valid=%b, want 0110/1", aluControl, out_valid);
    end
  endtask

  task automatic test_itype();
    logic [5:0] opcs [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b111111};
    logic [3:0] want [5] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 2'b10, opcs[i], 6'b100010);
      tests++;
      if (aluControl !== want[i] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL itype[%0d] opcode=%b: ctrl=%b valid=%b, want %b/1",
                 i, opcs[i], aluControl, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [3:0] want [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 2'b11, 6'b000000, fns[i]);
      tests++;
      if (aluControl !== want[i] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL rtype[%0d] funct=%b: ctrl=%b valid=%b, want %b/1",
                 i, fns[i], aluControl, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 1'b1, 2'b11, 6'd0, 6'b100010);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 2'b10, 6'b001100, 6'b100100);
      tests++;
      if (aluControl !== 4'b0110 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: ctrl=%b valid=%b, want 0110/0", i, aluControl, out_valid);
      end
    end
  endtask

  task automatic test_reset_priority();
    cycle(1'b1, 1'b1, 2'b11, 6'd0, 6'b100100);
    cycle(1'b0, 1'b1, 2'b11, 6'd0, 6'b100000);
    tests++;
    if (aluControl !== CTRL_RST || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: ctrl=%b valid=%b, want %b/0", aluControl, out_valid, CTRL_RST);
    end
  endtask

  task automatic test_midstream_reset();
    cycle(1'b1, 1'b1, 2'b10, 6'b001101, 6'd0);
    cycle(1'b0, 1'b1, 2'b10, 6'b001010, 6'd0);
    cycle(1'b1, 1'b0, 2'b10, 6'b001000, 6'd0);
    tests++;
    if (aluControl !== CTRL_RST || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midstream_idle: ctrl=%b valid=%b, want %b/0", aluControl, out_valid, CTRL_RST);
    end
    cycle(1'b1, 1'b1, 2'b10, 6'b001010, 6'd0);
    tests++;
    if (aluControl !== 4'b0111 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midstream_first: ctrl=%b valid=%b, want 0111/1", aluControl, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal_op [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] opc, fn;
    logic       v, rn;
    for (int i = 0; i < 300; i++) begin
      opc = ($urandom_range(0, 3) != 0) ? legal_op[$urandom_range(0, 3)] : 6'($urandom);
      fn  = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 29) != 0);
      cycle(rn, v, 2'($urandom), opc, fn);
      tests++;
      if (aluControl !== exp_ctrl || out_valid !== exp_valid) begin
        fails++;
        $display("FAIL random[%0d]: ctrl=%b valid=%b, want %b/%b",
                 i, aluControl, out_valid, exp_ctrl, exp_valid);
      end
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
      tests++;
      if (illegal !== exp_ill) begin
        fails++;
        $display("FAIL random_illegal[%0d]: illegal=%b, want %b", i, illegal, exp_ill);
      end
`endif
    end
  endtask

`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  task automatic test_illegal_flag();
    cycle(1'b1, 1'b1, 2'b11, 6'd0, 6'b111111);
    tests++;
    if (illegal !== 1'b1 || aluControl !== 4'b1111) begin
      fails++;
      $display("FAIL illegal_set: illegal=%b ctrl=%b, want 1/1111", illegal, aluControl);
    end
    cycle(1'b1, 1'b1, 2'b11, 6'd0, 6'b100000);
    tests++;
    if (illegal !== 1'b0 || aluControl !== 4'b0010) begin
      fails++;
      $display("FAIL illegal_clear: illegal=%b ctrl=%b, want 0/0010", illegal, aluControl);
    end
    cycle(1'b0, 1'b1, 2'b11, 6'd0, 6'b111111);
    tests++;
    if (illegal !== 1'b0) begin
      fails++;
      $display("FAIL illegal_reset: illegal=%b, want 0", illegal);
    end
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    exp_ctrl = CTRL_RST; exp_valid = 1'b0; exp_ill = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; aluop = 2'd0; opcode = 6'd0; funct = 6'd0;
    itab[6'b001000] = 4'b0010; itab[6'b001100] = 4'b0000;
    itab[6'b001101] = 4'b0001; itab[6'b001010] = 4'b0111;
    rtab[6'b100000] = 4'b0010; rtab[6'b100010] = 4'b0110;
    rtab[6'b100100] = 4'b0000; rtab[6'b100101] = 4'b0001;
    rtab[6'b101010] = 4'b0111;

    test_reset();
    test_mem_branch();
    test_itype();
    test_rtype();
    test_hold();
    test_reset_priority();
    test_midstream_reset();
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
    test_illegal_flag();
`endif
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
